// File: rtl/sha256_pkg.sv
// SHA-256 constants, round functions and engine state encoding shared by
// the round datapath and the iterative engine.
package sha256_pkg;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN, S_ADD, S_DONE} state_e;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [7:0][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// Job-in / result-out handshake bundle for the SHA-256 round engine.
interface sha256_round_engine_if #(parameter int TAG_W = 32);
    logic             in_valid;
    logic             in_ready;
    logic [255:0]     in_state;
    logic [511:0]     in_block;
    logic             in_ff;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [255:0]     out_hash;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_state, in_block, in_ff, in_tag, out_ready,
        input  in_ready, out_valid, out_hash, out_tag
    );

    modport slave (
        input  in_valid, in_state, in_block, in_ff, in_tag, out_ready,
        output in_ready, out_valid, out_hash, out_tag
    );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus one message-schedule step.
// st[7] is a ... st[0] is h; win[15] is the word consumed by this round.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [7:0][31:0]  st,
    input  logic [31:0]       k,
    input  logic [15:0][31:0] win,
    output logic [7:0][31:0]  st_nx,
    output logic [15:0][31:0] win_nx
);
    logic [31:0] t1, t2;

    assign t1 = st[0] + big_sigma1(st[3]) + ch(st[3], st[2], st[1]) + k + win[15];
    assign t2 = big_sigma0(st[7]) + maj(st[7], st[6], st[5]);

    assign st_nx  = {t1 + t2, st[7:5], st[4] + t1, st[3:1]};
    // Words past W63 get computed on the last cycle too; they are simply discarded.
    assign win_nx = {win[14:0], small_sigma1(win[1]) + win[6] + small_sigma0(win[14]) + win[15]};
endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression: UNROLL chained rounds per clock, optional
// feed-forward add, tag pass-through, valid/ready on both sides.
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int UNROLL = 4,
    parameter int TAG_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sha256_round_engine_if.slave   bus,
    output logic                   busy
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("sha256_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
    end

    state_e            state, state_nx;
    logic              ready_q, valid_q, busy_q;
    logic [7:0][31:0]  st, h_sv, hash_q, st_run;
    logic [15:0][31:0] win, win_run;
    logic              ff_sv;
    logic [TAG_W-1:0]  tag_sv, tag_q;
    logic [5:0]        rnd;
    logic              rnd_last, rnd_bad;

    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        logic [7:0][31:0]  st_i, st_o;
        logic [15:0][31:0] win_i, win_o;
        if (j == 0) begin : g_head
            assign st_i  = st;
            assign win_i = win;
        end else begin : g_link
            assign st_i  = g_rnd[j-1].st_o;
            assign win_i = g_rnd[j-1].win_o;
        end
        sha256_round u_round (
            .st     (st_i),
            .k      (K[rnd + 6'(j)]),
            .win    (win_i),
            .st_nx  (st_o),
            .win_nx (win_o)
        );
    end

    assign st_run  = g_rnd[UNROLL-1].st_o;
    assign win_run = g_rnd[UNROLL-1].win_o;

    assign rnd_last = (7'(rnd) + 7'(UNROLL)) == 7'd64;
    // rnd always steps by UNROLL from 0, so any off-stride value means corruption.
    assign rnd_bad  = (rnd & 6'(UNROLL - 1)) != 6'd0;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nx = S_RUN;
            S_RUN:   if (rnd_bad) state_nx = S_IDLE;
                     else if (rnd_last) state_nx = S_ADD;
            S_ADD:   state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= state_nx == S_IDLE;
            valid_q <= state_nx == S_DONE;
            busy_q  <= state_nx != S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= '0;
            win    <= '0;
            h_sv   <= '0;
            ff_sv  <= 1'b0;
            tag_sv <= '0;
            rnd    <= '0;
            hash_q <= '0;
            tag_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    st     <= bus.in_state;
                    win    <= bus.in_block;
                    h_sv   <= bus.in_state;
                    ff_sv  <= bus.in_ff;
                    tag_sv <= bus.in_tag;
                    rnd    <= '0;
                end
                S_RUN: begin
                    st  <= st_run;
                    win <= win_run;
                    rnd <= rnd + 6'(UNROLL);
                end
                S_ADD: begin
                    for (int i = 0; i < 8; i++)
                        hash_q[i] <= st[i] + (ff_sv ? h_sv[i] : 32'd0);
                    tag_q <= tag_sv;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_hash  = hash_q;
    assign bus.out_tag   = tag_q;
    assign busy          = busy_q;
endmodule

// File: doc/sha256_round_engine.md
# sha256_round_engine

Iterative SHA-256 compression engine that processes one 512-bit message block against a 256-bit chaining state in 64/UNROLL cycles. It generalises the fixed pipelined transform to a configurable rounds-per-cycle datapath, adds valid/ready handshakes on both sides, an optional final feed-forward addition and a pass-through tag. It sits between the work dispatcher (midstate plus nonce block) and the hash comparator, and can be chained for double hashing.

## Interface

- `UNROLL`, default 4: rounds evaluated per clock. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- `TAG_W`, default 32: width of the opaque tag carried with each job (for example, the nonce).
- `clk` input, 1: single clock, rising-edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: job offered.
- `in_ready` output, 1: engine can accept a job.
- `in_state` input, 256: chaining state. Bits [255:224] are H0 (a) and bits [31:0] are H7 (h).
- `in_block` input, 512: message block. Bits [511:480] are W0 (first big-endian word) and bits [31:0] are W15.
- `in_ff` input, 1: 1 means add `in_state` to the result (standard digest); 0 means output raw working variables.
- `in_tag` input, TAG_W: returned unchanged with the result.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: consumer accepts the result.
- `out_hash` output, 256: result, in the same word order as `in_state`.
- `out_tag` output, TAG_W: the tag of the job that produced `out_hash`.
- `busy` output, 1: high in any state other than IDLE.

## Operation

- FSM states are IDLE, RUN, ADD and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_state` (kept as the feed-forward copy), `in_ff` and `in_tag`.
  - Load a..h from `in_state` and the 16-word W window from `in_block`.
  - Clear the round counter `rnd`=0 and go to RUN.
- RUN:
  - Each edge applies rounds rnd..rnd+UNROLL-1 in sequence, using K[rnd+j] and W[rnd+j].
  - The W window shifts by UNROLL words. New words use W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16], all mod 2^32.
  - `rnd` advances by UNROLL. On the edge where rnd+UNROLL==64, go to ADD.
- ADD:
  - One edge. `out_hash` word i is working var i + (ff ? saved H_i : 0), mod 2^32 per word with no carry between words.
  - `out_tag` takes the saved tag. Go to DONE.
- DONE:
  - `out_valid`=1. `out_hash` and `out_tag` stay stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. There is no queueing.
- `out_hash` and `out_tag` hold their last value after the handshake; they are only meaningful while `out_valid` is high.
- `rnd` is 6 bits wide and never wraps mid-job. An illegal counter value forces IDLE.

## Timing

- Reset values:
  - FSM in IDLE, so `in_ready`=1.
  - `out_valid`=0 and `busy`=0.
  - `out_hash`=0 and `out_tag`=0.
  - Working registers are zeroed.
- Reset asserted mid-job aborts the job immediately. No result is produced and the job is lost.
- Latency: with N=64/UNROLL, `out_valid` rises N+1 edges after the accept edge.
- Throughput with `out_ready` held high: one job per N+3 cycles, made up of accept, N×RUN, ADD and DONE. The DONE→IDLE handshake edge and the next accept edge are distinct.
- `in_ready` is a registered function of state only and does not depend on `in_valid`.
- `out_valid` is registered and does not depend on `out_ready`.
- Critical path is UNROLL chained rounds, so the target clock fixes the choice of UNROLL.

## Structure

- Package `sha256_pkg` holds:
  - the 64-entry K table as a localparam array;
  - the IV H0..H7 (6a09e667 … 5be0cd19);
  - functions Σ0, Σ1, σ0, σ1, Ch and Maj;
  - the FSM state enum.
- Sub-module `sha256_round` is a combinational single round plus schedule step: inputs a..h, K and a 16-word window; outputs the next a..h and next window. It is instantiated UNROLL times in a generate chain. The engine owns all registers, the FSM and the counter.

## Test plan

- Standard "abc" digest, run for each UNROLL in {1,4,16}:
  - Stimulus: `in_state`=IV; `in_block`=61626380 followed by fourteen zero words, then 00000018; `in_ff`=1; `in_tag`=0xDEADBEEF.
  - Response: `out_hash`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad and `out_tag`=DEADBEEF.
  - Response: `out_valid` rises exactly 64/UNROLL+1 edges after accept.
- Same job with `in_ff`=0 → each `out_hash` word equals the matching "abc" digest word minus the matching IV word, mod 2^32.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles → `out_valid` and `out_hash` stay stable and `in_ready` stays 0.
  - A second `in_valid` during this time is not accepted.
  - Release `out_ready` → handshake, then IDLE one edge later.
- Back-to-back jobs with `out_ready`=1, two "abc" jobs tagged 1 and 2 → both digests correct, tags in order, accept edges N+3 cycles apart.
- Assert `rst_n`=0 mid-RUN (rnd=32) → asynchronously `out_valid`=0, `busy`=0, `in_ready`=1, `out_hash`=0. A fresh job afterwards yields the correct digest.
- Double hash: feed the "abc" digest, padded (digest words, 80000000, six zero words, 00000100), with IV and `in_ff`=1 → `out_hash`=4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358.
